rtds_frame_gen: RTL and testbench

Transmit-side frame generator that emulates the RTDS end of the augmented-Aurora link. It produces AXI-Stream frames of a fixed payload length, each closed by a trailing 32-bit sequence-number word that carries `tlast`. The receive-path stripper removes exactly this trailer. The block drives the Aurora TX stream (or the `pre` input) in loopback and bring-up builds, and it acts as the stimulus source for verifying sequence-strip and loss-detection logic.

---
 rtl/rtds_frame_gen_if.sv | 12 +
 rtl/rtds_frame_gen.sv | 136 +++++++++++++
 tb/tb_rtds_frame_gen.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtds_frame_gen_if.sv
// AXI-Stream handshake bundle carrying the RTDS frame generator's TX beats.
interface rtds_frame_gen_if;
  localparam int unsigned DATA_W = 32;

  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rtds_frame_gen.sv
// RTDS-side frame generator: fixed-length payload frames, each closed by a
// 32-bit sequence-number trailer beat carrying tlast, separated by idle gaps.
module rtds_frame_gen #(
  parameter int unsigned PAYLOAD_WORDS = 8,
  parameter int unsigned GAP_CYCLES    = 4,
  parameter logic [31:0] SEQ_INIT      = 32'h0000_0000
) (
  input  logic                   m_axis_aclk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  rtds_frame_gen_if.master       m_axis,
  output logic                   busy,
  output logic [31:0]            seq_out,
  output logic [31:0]            frames_sent
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned GAP_W = 16;
  localparam int unsigned SEQ_W = 32;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_WORDS - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam bit               HAS_GAP  = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_TRAILER,
    ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [SEQ_W-1:0]   frames_q, frames_d;
  logic               tvalid_q, tvalid_d;
  logic [SEQ_W-1:0]   tdata_q, tdata_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               hs_c;

  assign hs_c = tvalid_q & m_axis.tready;

  // Next-state, counters and the registered beat that goes with the next state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    seq_d    = seq_q;
    frames_d = frames_q;

    unique case (state_q)
      ST_IDLE: begin
        if (enable || start) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (hs_c) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (hs_c) begin
          seq_d    = seq_q + SEQ_W'(1);
          frames_d = frames_q + SEQ_W'(1);
          if (HAS_GAP) begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end else if (enable) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          if (enable) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Beat contents only change when a new beat is presented, so data holds while stalled.
    tvalid_d = (state_d == ST_PAYLOAD) || (state_d == ST_TRAILER);
    tlast_d  = (state_d == ST_TRAILER);
    busy_d   = (state_d != ST_IDLE);
    tdata_d  = tdata_q;
    if (state_d == ST_PAYLOAD)      tdata_d = {seq_d[23:0], idx_d};
    else if (state_d == ST_TRAILER) tdata_d = seq_d;
  end

  always_ff @(posedge m_axis_aclk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      seq_q    <= SEQ_INIT;
      frames_q <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      seq_q    <= seq_d;
      frames_q <= frames_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign seq_out       = seq_q;
  assign frames_sent   = frames_q;

endmodule

// File: tb/tb_rtds_frame_gen.sv
// Randomised self-checking bench for rtds_frame_gen against a frame-stream model.
module tb_rtds_frame_gen;

  localparam int unsigned PW_A  = 4;
  localparam int unsigned GAP_A = 2;
  localparam logic [31:0] SEQ_A = 32'h0000_0000;
  localparam int unsigned P_A   = PW_A + 1 + GAP_A;

  localparam int unsigned PW_B  = 4;
  localparam int unsigned GAP_B = 0;
  localparam logic [31:0] SEQ_B = 32'hFFFF_FFFF;
  localparam int unsigned P_B   = PW_B + 1 + GAP_B;

  logic        clk = 1'b0;
  logic        rst_a, en_a, st_a, busy_a;
  logic [31:0] seq_a, fs_a;
  logic        rst_b, en_b, st_b, busy_b;
  logic [31:0] seq_b, fs_b;

  int n_cmp = 0;
  int n_err = 0;

  rtds_frame_gen_if ifa ();
  rtds_frame_gen_if ifb ();

  rtds_frame_gen #(.PAYLOAD_WORDS(PW_A), .GAP_CYCLES(GAP_A), .SEQ_INIT(SEQ_A)) dut_a (
    .m_axis_aclk(clk), .reset(rst_a), .enable(en_a), .start(st_a),
    .m_axis(ifa), .busy(busy_a), .seq_out(seq_a), .frames_sent(fs_a));

  rtds_frame_gen #(.PAYLOAD_WORDS(PW_B), .GAP_CYCLES(GAP_B), .SEQ_INIT(SEQ_B)) dut_b (
    .m_axis_aclk(clk), .reset(rst_b), .enable(en_b), .start(st_b),
    .m_axis(ifb), .busy(busy_b), .seq_out(seq_b), .frames_sent(fs_b));

  always #5 clk = ~clk;

  // Expected beat: frame k carries seq0+k; payload word i is {seq[23:0], i}, trailer is seq.
  function automatic logic [31:0] beat_data(logic [31:0] seq0, int unsigned frame,
                                            int unsigned pos, int unsigned pw);
    logic [31:0] s;
    s = seq0 + 32'(frame);
    if (pos == pw) return s;
    return {s[23:0], 8'(pos)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_a();
    rst_a = 1'b1; en_a = 1'b0; st_a = 1'b0; ifa.tready = 1'b1;
    tick(); tick();
    rst_a = 1'b0;
  endtask

  task automatic do_reset_b();
    rst_b = 1'b1; en_b = 1'b0; st_b = 1'b0; ifb.tready = 1'b1;
    tick(); tick();
    rst_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; en_a = 1'b1; st_a = 1'b0; ifa.tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({ifa.tvalid, ifa.tlast, busy_a} !== 3'b000 || ifa.tdata !== 32'h0 ||
          seq_a !== SEQ_A || fs_a !== 32'h0) begin
        n_err++;
        $display("FAIL reset_values c%0d: got v%b l%b b%b d%h s%h f%h expected all zero, seq %h",
                 c, ifa.tvalid, ifa.tlast, busy_a, ifa.tdata, seq_a, fs_a, SEQ_A);
      end
    end
    rst_a = 1'b0; en_a = 1'b0;
    n_cmp++;
    if (ifa.tvalid !== 1'b0) begin
      n_err++; $display("FAIL reset_release_valid: got %b expected 0", ifa.tvalid);
    end
    tick();
    n_cmp++;
    if (ifa.tvalid !== 1'b0 || busy_a !== 1'b0 || seq_a !== 32'h0) begin
      n_err++;
      $display("FAIL reset_idle: got v%b b%b s%h expected v0 b0 s00000000", ifa.tvalid, busy_a, seq_a);
    end
  endtask

  // Cycle-exact check: frames 0..2 run with no backpressure, enable dropped inside frame 2.
  task automatic test_continuous();
    int unsigned frame, pos, exp_fs;
    bit act, exp_v;
    do_reset_a();
    en_a = 1'b1;
    tick();
    for (int t = 0; t < int'(4 * P_A); t++) begin
      if (t == int'(2 * P_A + 1)) en_a = 1'b0;
      frame  = t / P_A;
      pos    = t % P_A;
      act    = (frame <= 2);
      exp_v  = act && (pos <= PW_A);
      exp_fs = act ? frame + ((pos > PW_A) ? 1 : 0) : 3;
      n_cmp++;
      if (ifa.tvalid !== exp_v || busy_a !== act || fs_a !== 32'(exp_fs) ||
          seq_a !== SEQ_A + 32'(exp_fs)) begin
        n_err++;
        $display("FAIL cont_ctrl t%0d: got v%b b%b f%0d s%h expected v%b b%b f%0d s%h",
                 t, ifa.tvalid, busy_a, fs_a, seq_a, exp_v, act, exp_fs, SEQ_A + 32'(exp_fs));
      end
      if (exp_v) begin
        n_cmp++;
        if (ifa.tdata !== beat_data(SEQ_A, frame, pos, PW_A) || ifa.tlast !== (pos == PW_A)) begin
          n_err++;
          $display("FAIL cont_beat t%0d: got %h/%b expected %h/%b", t, ifa.tdata, ifa.tlast,
                   beat_data(SEQ_A, frame, pos, PW_A), (pos == PW_A));
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int unsigned beats;
    bit rdy, prev_stall, done;
    logic [31:0] prev_d;
    logic prev_l;
    beats = 0; prev_stall = 1'b0; done = 1'b0; prev_d = '0; prev_l = 1'b0;
    do_reset_a();
    en_a = 1'b1;
    tick();
    for (int c = 0; c < 2000 && !done; c++) begin
      if (beats >= 5 * (PW_A + 1)) en_a = 1'b0;
      rdy = 1'($urandom_range(0, 1));
      ifa.tready = rdy;
      if (prev_stall) begin
        n_cmp++;
        if (ifa.tvalid !== 1'b1 || ifa.tdata !== prev_d || ifa.tlast !== prev_l) begin
          n_err++;
          $display("FAIL bp_stable c%0d: got v%b %h/%b expected v1 %h/%b",
                   c, ifa.tvalid, ifa.tdata, ifa.tlast, prev_d, prev_l);
        end
      end
      if (ifa.tvalid === 1'b1 && rdy) begin
        n_cmp++;
        if (ifa.tdata !== beat_data(SEQ_A, beats / (PW_A + 1), beats % (PW_A + 1), PW_A) ||
            ifa.tlast !== ((beats % (PW_A + 1)) == PW_A)) begin
          n_err++;
          $display("FAIL bp_beat %0d: got %h/%b expected %h/%b", beats, ifa.tdata, ifa.tlast,
                   beat_data(SEQ_A, beats / (PW_A + 1), beats % (PW_A + 1), PW_A),
                   ((beats % (PW_A + 1)) == PW_A));
        end
        beats++;
      end
      prev_stall = (ifa.tvalid === 1'b1) && !rdy;
      prev_d = ifa.tdata;
      prev_l = ifa.tlast;
      if (!en_a && busy_a === 1'b0) done = 1'b1;
      else tick();
    end
    ifa.tready = 1'b1;
    n_cmp++;
    if (!done || (beats % (PW_A + 1)) != 0 || fs_a !== 32'(beats / (PW_A + 1))) begin
      n_err++;
      $display("FAIL bp_total: got done%b beats%0d frames%0d expected done1 whole frames %0d",
               done, beats, fs_a, beats / (PW_A + 1));
    end
  endtask

  task automatic test_back_to_back();
    int unsigned frame, pos;
    bit act;
    do_reset_b();
    en_b = 1'b1;
    tick();
    for (int t = 0; t < int'(3 * P_B + 3); t++) begin
      if (t == int'(2 * P_B + 1)) en_b = 1'b0;
      frame = t / P_B;
      pos   = t % P_B;
      act   = (frame <= 2);
      n_cmp++;
      if (ifb.tvalid !== act || busy_b !== act || fs_b !== 32'(act ? frame : 3) ||
          seq_b !== SEQ_B + 32'(act ? frame : 3)) begin
        n_err++;
        $display("FAIL b2b_ctrl t%0d: got v%b b%b f%0d s%h expected v%b f%0d s%h", t, ifb.tvalid,
                 busy_b, fs_b, seq_b, act, act ? frame : 3, SEQ_B + 32'(act ? frame : 3));
      end
      if (act) begin
        n_cmp++;
        if (ifb.tdata !== beat_data(SEQ_B, frame, pos, PW_B) || ifb.tlast !== (pos == PW_B)) begin
          n_err++;
          $display("FAIL b2b_beat t%0d: got %h/%b expected %h/%b", t, ifb.tdata, ifb.tlast,
                   beat_data(SEQ_B, frame, pos, PW_B), (pos == PW_B));
        end
      end
      tick();
    end
  endtask

  task automatic test_single_shot();
    bit exp_v, exp_b;
    do_reset_a();
    st_a = 1'b1;
    tick();
    st_a = 1'b0;
    for (int t = 0; t < int'(3 * P_A); t++) begin
      st_a  = (t == 2);
      exp_v = (t <= int'(PW_A));
      exp_b = (t < int'(P_A));
      n_cmp++;
      if (ifa.tvalid !== exp_v || busy_a !== exp_b || fs_a !== 32'((t > int'(PW_A)) ? 1 : 0)) begin
        n_err++;
        $display("FAIL single_ctrl t%0d: got v%b b%b f%0d expected v%b b%b f%0d", t, ifa.tvalid,
                 busy_a, fs_a, exp_v, exp_b, (t > int'(PW_A)) ? 1 : 0);
      end
      if (exp_v) begin
        n_cmp++;
        if (ifa.tdata !== beat_data(SEQ_A, 0, t, PW_A) || ifa.tlast !== (t == int'(PW_A))) begin
          n_err++;
          $display("FAIL single_beat t%0d: got %h/%b expected %h/%b", t, ifa.tdata, ifa.tlast,
                   beat_data(SEQ_A, 0, t, PW_A), (t == int'(PW_A)));
        end
      end
      tick();
    end
    st_a = 1'b0;
  endtask

  task automatic test_abort();
    do_reset_a();
    en_a = 1'b1;
    tick();
    for (int t = 0; t < int'(P_A + 2); t++) tick();
    n_cmp++;
    if (ifa.tvalid !== 1'b1 || ifa.tdata !== 32'h0000_0102 || seq_a !== 32'h1) begin
      n_err++;
      $display("FAIL abort_pre: got v%b %h s%h expected v1 00000102 s00000001",
               ifa.tvalid, ifa.tdata, seq_a);
    end
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    n_cmp++;
    if (ifa.tvalid !== 1'b0 || busy_a !== 1'b0 || fs_a !== 32'h0 || seq_a !== SEQ_A) begin
      n_err++;
      $display("FAIL abort_cut: got v%b b%b f%0d s%h expected v0 b0 f0 s%h",
               ifa.tvalid, busy_a, fs_a, seq_a, SEQ_A);
    end
    tick();
    for (int p = 0; p <= int'(PW_A); p++) begin
      n_cmp++;
      if (ifa.tvalid !== 1'b1 || ifa.tdata !== beat_data(SEQ_A, 0, p, PW_A) ||
          ifa.tlast !== (p == int'(PW_A)) || seq_a !== SEQ_A) begin
        n_err++;
        $display("FAIL abort_restart p%0d: got v%b %h/%b s%h expected v1 %h/%b s%h", p, ifa.tvalid,
                 ifa.tdata, ifa.tlast, seq_a, beat_data(SEQ_A, 0, p, PW_A), (p == int'(PW_A)), SEQ_A);
      end
      if (p == int'(PW_A)) en_a = 1'b0;
      tick();
    end
    for (int c = 0; c < int'(GAP_A + 2); c++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; en_a = 1'b0; st_a = 1'b0; ifa.tready = 1'b1;
    rst_b = 1'b1; en_b = 1'b0; st_b = 1'b0; ifb.tready = 1'b1;
    tick();
    do_reset_b();
    test_reset();
    test_continuous();
    test_backpressure();
    test_back_to_back();
    test_single_shot();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
